// File: rtl/pmem_pkg.sv
// Shared types for the fetch/load-store memory arbiter: FSM states, owners, default widths.
package pmem_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single memory port.
interface pmem_arbiter_if #(
    parameter int ADDR_W = pmem_pkg::DEF_ADDR_W,
    parameter int DATA_W = pmem_pkg::DEF_DATA_W
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_resp_valid;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_W-1:0]     ls_addr;
    logic                  ls_wen;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_wmask;
    logic                  ls_resp_valid;

    logic [DATA_W-1:0]     resp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid,
        output ls_req_ready, ls_resp_valid, resp_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    // Environment side: requesters plus memory model.
    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid,
        input  ls_req_ready, ls_resp_valid, resp_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; req[0]/gnt[0] is fetch, req[1]/gnt[1] is load/store.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Set when load/store won the last grant; cleared so the first tie goes to load/store.
    logic last_ls;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_ls ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls <= 1'b0;
        end else if (en && (gnt != 2'b00)) begin
            last_ls <= gnt[1];
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one memory port between fetch and load/store, one outstanding transaction at a time.
module pmem_arbiter
    import pmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    pmem_arbiter_if.slave   bus
);

    localparam int MASK_W = DATA_W / 8;

    state_t              state;
    owner_t              owner;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                idle;
    logic                done;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    assign idle = (state == S_IDLE);
    assign req  = {bus.ls_req_valid, bus.if_req_valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (idle),
        .gnt (gnt)
    );

    assign bus.if_req_ready  = idle & gnt[0];
    assign bus.ls_req_ready  = idle & gnt[1];

    assign bus.mem_req_valid = (state == S_REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    // Completions outside WAIT are stray pulses and never reach a requester.
    assign done              = (state == S_WAIT) & bus.mem_resp_valid;
    assign bus.if_resp_valid = done & (owner == OWN_IF);
    assign bus.ls_resp_valid = done & (owner == OWN_LS);
    assign bus.resp_rdata    = done ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= OWN_LS;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt[1]) begin
                        owner   <= OWN_LS;
                        addr_q  <= bus.ls_addr;
                        wen_q   <= bus.ls_wen;
                        wdata_q <= bus.ls_wdata;
                        wmask_q <= bus.ls_wmask;
                        state   <= S_REQ;
                    end else if (gnt[0]) begin
                        owner   <= OWN_IF;
                        addr_q  <= bus.if_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
